// File: rtl/trace_pkg.sv
// Shared types and default widths for the trace request queue.
package trace_pkg;

  localparam int unsigned TRACE_DEPTH  = 16;
  localparam int unsigned TRACE_TIME_W = 64;
  localparam int unsigned TRACE_CORE_W = 12;
  localparam int unsigned TRACE_ADDR_W = 36;

  typedef enum logic [1:0] {
    OP_READ    = 2'd0,
    OP_WRITE   = 2'd1,
    OP_IFETCH  = 2'd2,
    OP_ILLEGAL = 2'd3
  } op_e;

  typedef struct packed {
    logic [TRACE_TIME_W-1:0] tstamp;
    logic [TRACE_CORE_W-1:0] core;
    op_e                     op;
    logic [TRACE_ADDR_W-1:0] addr;
  } req_t;

  localparam logic [1:0] ST_EMPTY      = 2'd0;
  localparam logic [1:0] ST_WAIT_TIME  = 2'd1;
  localparam logic [1:0] ST_WAIT_SPACE = 2'd2;

endpackage

// File: rtl/trace_req_fifo.sv
// Generic DEPTH-entry synchronous FIFO of entry type T with occupancy count.
module trace_req_fifo
  import trace_pkg::*;
#(
  parameter int unsigned DEPTH = TRACE_DEPTH,
  parameter type         T     = req_t
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  T                       wdata_i,
  input  logic                   pop_i,
  output T                       rdata_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int unsigned PW = $clog2(DEPTH);

  T                 mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [PW:0]      count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage carries no reset; the head is masked by the top when empty.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == (PW+1)'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/trace_request_queue.sv
// Time-gated trace request queue feeding the DRAM scheduler; owns sim_time.
// Optional idle time skip enabled by defining TRACE_TIME_SKIP_EN.
module trace_request_queue
  import trace_pkg::*;
#(
  parameter int unsigned DEPTH  = TRACE_DEPTH,
  parameter int unsigned TIME_W = TRACE_TIME_W,
  parameter int unsigned CORE_W = TRACE_CORE_W,
  parameter int unsigned ADDR_W = TRACE_ADDR_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [TIME_W-1:0]      in_time,
  input  logic [CORE_W-1:0]      in_core,
  input  logic [1:0]             in_op,
  input  logic [ADDR_W-1:0]      in_addr,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [TIME_W-1:0]      out_time,
  output logic [CORE_W-1:0]      out_core,
  output logic [1:0]             out_op,
  output logic [ADDR_W-1:0]      out_addr,
  output logic [TIME_W-1:0]      sim_time,
  output logic [$clog2(DEPTH):0] q_count,
  output logic                   q_full,
  output logic                   err_op,
  output logic                   err_order
);

  typedef struct packed {
    logic [TIME_W-1:0] tstamp;
    logic [CORE_W-1:0] core;
    op_e               op;
    logic [ADDR_W-1:0] addr;
  } entry_t;

  logic [1:0]        state_q, state_d;
  entry_t            stage_q, stage_d;
  logic [TIME_W-1:0] sim_time_q, sim_time_d;
  logic [TIME_W-1:0] last_time_q, last_time_d;
  logic              err_op_q, err_op_d;
  logic              err_order_q, err_order_d;

  entry_t            head;
  logic              fifo_full, fifo_empty;
  logic              accept, pop, time_ok, pending, release_req;

  assign in_ready    = (state_q == ST_EMPTY);
  assign accept      = in_valid && in_ready;
  assign out_valid   = !fifo_empty;
  assign pop         = out_valid && out_ready;
  assign time_ok     = (sim_time_q >= stage_q.tstamp);
  // WAIT_TIME with time reached folds straight into the space check.
  assign pending     = ((state_q == ST_WAIT_TIME) && time_ok) || (state_q == ST_WAIT_SPACE);
  assign release_req = pending && (!fifo_full || pop);

  always_comb begin
    state_d     = state_q;
    stage_d     = stage_q;
    last_time_d = last_time_q;
    err_op_d    = 1'b0;
    err_order_d = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          if (in_op == OP_ILLEGAL) begin
            err_op_d = 1'b1;
          end else begin
            stage_d.tstamp = in_time;
            stage_d.core   = in_core;
            stage_d.op     = op_e'(in_op);
            stage_d.addr   = in_addr;
            last_time_d    = in_time;
            err_order_d    = (in_time < last_time_q);
            state_d        = ST_WAIT_TIME;
          end
        end
      end
      ST_WAIT_TIME: begin
        if (time_ok) state_d = release_req ? ST_EMPTY : ST_WAIT_SPACE;
      end
      ST_WAIT_SPACE: begin
        if (release_req) state_d = ST_EMPTY;
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_comb begin
    sim_time_d = sim_time_q + 1'b1;
`ifdef TRACE_TIME_SKIP_EN
    if (fifo_empty && (state_q == ST_WAIT_TIME) &&
        (stage_q.tstamp > sim_time_q + TIME_W'(1))) begin
      sim_time_d = stage_q.tstamp;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      stage_q     <= '0;
      sim_time_q  <= '0;
      last_time_q <= '0;
      err_op_q    <= 1'b0;
      err_order_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      stage_q     <= stage_d;
      sim_time_q  <= sim_time_d;
      last_time_q <= last_time_d;
      err_op_q    <= err_op_d;
      err_order_q <= err_order_d;
    end
  end

  trace_req_fifo #(
    .DEPTH (DEPTH),
    .T     (entry_t)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (release_req),
    .wdata_i (stage_q),
    .pop_i   (pop),
    .rdata_o (head),
    .count_o (q_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign out_time  = out_valid ? head.tstamp : '0;
  assign out_core  = out_valid ? head.core   : '0;
  assign out_op    = out_valid ? head.op     : '0;
  assign out_addr  = out_valid ? head.addr   : '0;
  assign sim_time  = sim_time_q;
  assign q_full    = fifo_full;
  assign err_op    = err_op_q;
  assign err_order = err_order_q;

endmodule
